// File: rtl/npc_pkg.sv
// Shared types and helpers for the next-PC predictor:
// mode constants, direction-counter encodings, index/tag widths.
package npc_pkg;

  localparam int MODE_STATIC = 0;
  localparam int MODE_1BIT   = 1;
  localparam int MODE_2BIT   = 2;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  function automatic int btb_idx_w(input int entries);
    return $clog2(entries);
  endfunction

  function automatic int btb_tag_w(input int xlen, input int entries);
    return xlen - $clog2(entries) - 2;
  endfunction

  function automatic logic [1:0] ctr_next(
    input logic [1:0] ctr,
    input logic       taken,
    input int         mode
  );
    logic [1:0] n;
    n = ctr;
    if (mode == MODE_2BIT) begin
      if (taken && ctr != ST)
        n = ctr + 2'd1;
      else if (!taken && ctr != SNT)
        n = ctr - 2'd1;
    end else if (mode == MODE_1BIT) begin
      n = taken ? ST : SNT;
    end
    return n;
  endfunction

endpackage

// File: rtl/npc_predict_unit_if.sv
// Hazard-unit / pipeline bundle around the next-PC unit.
// slave is the unit's view, master is the driver's view.
interface npc_predict_unit_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
);
  logic            stall_f;
  logic            jal_d;
  logic [XLEN-1:0] jal_target_d;
  logic            jalr_e;
  logic [XLEN-1:0] jalr_target_e;
  logic            br_e;
  logic            br_taken_e;
  logic [XLEN-1:0] br_target_e;
  logic [XLEN-1:0] pc_e;
  logic            pred_taken_e;
  logic [XLEN-1:0] pc_f;
  logic            pred_taken_f;
  logic            mispredict_e;
  logic [CNT_W-1:0] cnt_branch;
  logic [CNT_W-1:0] cnt_mispred;

  modport slave (
    input  stall_f, jal_d, jal_target_d,
    input  jalr_e, jalr_target_e,
    input  br_e, br_taken_e, br_target_e,
    input  pc_e, pred_taken_e,
    output pc_f, pred_taken_f, mispredict_e,
    output cnt_branch, cnt_mispred
  );

  modport master (
    output stall_f, jal_d, jal_target_d,
    output jalr_e, jalr_target_e,
    output br_e, br_taken_e, br_target_e,
    output pc_e, pred_taken_e,
    input  pc_f, pred_taken_f, mispredict_e,
    input  cnt_branch, cnt_mispred
  );
endinterface

// File: rtl/npc_predict_unit_btb_bank.sv
// Direct-mapped BTB storage: fetch lookup port, EX lookup port,
// and one synchronous write port at the EX index.
module btb_bank
  import npc_pkg::*;
#(
  parameter int ENTRIES = 64,
  parameter int IDX_W   = 6,
  parameter int TAG_W   = 24,
  parameter int TGT_W   = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [IDX_W-1:0] rd_idx,
  input  logic [TAG_W-1:0] rd_tag,
  output logic             rd_hit,
  output logic [TGT_W-1:0] rd_tgt,
  output logic [1:0]       rd_ctr,
  input  logic [IDX_W-1:0] ex_idx,
  input  logic [TAG_W-1:0] ex_tag,
  output logic             ex_hit,
  output logic [TGT_W-1:0] ex_tgt,
  output logic [1:0]       ex_ctr,
  input  logic             we,
  input  logic [TGT_W-1:0] wr_tgt,
  input  logic [1:0]       wr_ctr
);

  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  logic [TAG_W-1:0]   tag_d [ENTRIES];
  logic [TGT_W-1:0]   tgt_q [ENTRIES];
  logic [TGT_W-1:0]   tgt_d [ENTRIES];
  logic [1:0]         ctr_q [ENTRIES];
  logic [1:0]         ctr_d [ENTRIES];

  // Reads see pre-update contents; no write bypass.
  assign rd_hit = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign rd_tgt = tgt_q[rd_idx];
  assign rd_ctr = ctr_q[rd_idx];
  assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
  assign ex_tgt = tgt_q[ex_idx];
  assign ex_ctr = ctr_q[ex_idx];

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    tgt_d   = tgt_q;
    ctr_d   = ctr_q;
    if (clr) begin
      valid_d = '0;
      for (int i = 0; i < ENTRIES; i++)
        ctr_d[i] = SNT;
    end else if (we) begin
      valid_d[ex_idx] = 1'b1;
      tag_d[ex_idx]   = ex_tag;
      tgt_d[ex_idx]   = wr_tgt;
      ctr_d[ex_idx]   = wr_ctr;
    end
  end

  always_ff @(posedge clk) begin
    valid_q <= valid_d;
    tag_q   <= tag_d;
    tgt_q   <= tgt_d;
    ctr_q   <= ctr_d;
  end

endmodule

// File: rtl/npc_predict_unit.sv
// IF-stage PC register, BTB-based prediction, EX resolution,
// redirect priority and branch statistics.
module npc_predict_unit
  import npc_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter int              BTB_ENTRIES = 64,
  parameter int              PRED_MODE   = 2,
  parameter logic [XLEN-1:0] RESET_PC    = '0,
  parameter int              CNT_W       = 32
) (
  input logic               clk,
  input logic               rst,
  npc_predict_unit_if.slave io
);

  localparam int IDX_W = btb_idx_w(BTB_ENTRIES);
  localparam int TAG_W = btb_tag_w(XLEN, BTB_ENTRIES);
  localparam logic [XLEN-1:0] FOUR = XLEN'(4);

  logic [XLEN-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] cnt_br_q, cnt_br_d;
  logic [CNT_W-1:0] cnt_mp_q, cnt_mp_d;

  logic             rd_hit, ex_hit;
  logic [XLEN-1:0]  rd_tgt, ex_tgt;
  logic [1:0]       rd_ctr, ex_ctr;
  logic             we;
  logic [XLEN-1:0]  wr_tgt;
  logic [1:0]       wr_ctr;

  logic             pred_f;
  logic             mispred;
  logic [XLEN-1:0]  fix_tgt;

  btb_bank #(
    .ENTRIES(BTB_ENTRIES),
    .IDX_W  (IDX_W),
    .TAG_W  (TAG_W),
    .TGT_W  (XLEN)
  ) u_btb (
    .clk   (clk),
    .clr   (rst),
    .rd_idx(pc_q[IDX_W+1:2]),
    .rd_tag(pc_q[XLEN-1:IDX_W+2]),
    .rd_hit(rd_hit),
    .rd_tgt(rd_tgt),
    .rd_ctr(rd_ctr),
    .ex_idx(io.pc_e[IDX_W+1:2]),
    .ex_tag(io.pc_e[XLEN-1:IDX_W+2]),
    .ex_hit(ex_hit),
    .ex_tgt(ex_tgt),
    .ex_ctr(ex_ctr),
    .we    (we),
    .wr_tgt(wr_tgt),
    .wr_ctr(wr_ctr)
  );

  assign pred_f = (PRED_MODE != MODE_STATIC) && !rst
               && rd_hit && rd_ctr[1];

  assign mispred =
      (io.br_e && (io.br_taken_e != io.pred_taken_e))
    || (!io.br_e && io.pred_taken_e);

  assign fix_tgt = (io.br_e && io.br_taken_e)
                 ? io.br_target_e : io.pc_e + FOUR;

  // EX redirects beat stall; fetch-side redirects obey it.
  always_comb begin
    pc_d = pc_q + FOUR;
    if (rst)
      pc_d = RESET_PC;
    else if (io.jalr_e)
      pc_d = io.jalr_target_e;
    else if (mispred)
      pc_d = fix_tgt;
    else if (io.stall_f)
      pc_d = pc_q;
    else if (io.jal_d)
      pc_d = io.jal_target_d;
    else if (pred_f)
      pc_d = rd_tgt;
  end

  always_comb begin
    we     = 1'b0;
    wr_tgt = io.br_target_e;
    wr_ctr = (PRED_MODE == MODE_2BIT) ? WT : ST;
    if (!rst && io.br_e && PRED_MODE != MODE_STATIC) begin
      if (ex_hit) begin
        we     = 1'b1;
        wr_tgt = ex_tgt;
        wr_ctr = ctr_next(ex_ctr, io.br_taken_e, PRED_MODE);
      end else if (io.br_taken_e) begin
        we = 1'b1;
      end
    end
  end

  always_comb begin
    cnt_br_d = cnt_br_q + CNT_W'(io.br_e);
    cnt_mp_d = cnt_mp_q + CNT_W'(mispred);
    if (rst) begin
      cnt_br_d = '0;
      cnt_mp_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    pc_q     <= pc_d;
    cnt_br_q <= cnt_br_d;
    cnt_mp_q <= cnt_mp_d;
  end

  assign io.pc_f         = pc_q;
  assign io.pred_taken_f = pred_f;
  assign io.mispredict_e = mispred;
  assign io.cnt_branch   = cnt_br_q;
  assign io.cnt_mispred  = cnt_mp_q;

endmodule
